// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the MIPS register-file writeback path.
package mips_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LSU
  } wb_gnt_e;

endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry valid/ready holding buffer for a writeback requester.
// Requests to r0 are accepted but never stored, so they never reach the port.
module wb_hold_buffer
  import mips_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  grant_i,
  output logic                  ready_o,
  output logic                  full_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [DATA_W-1:0]     data_o
);

  logic    full_q, full_d;
  wb_req_t req_q, req_d;
  logic    load;

  // Ready when empty or draining this cycle; a new entry replaces a granted one.
  always_comb begin
    ready_o = !reset && (!full_q || grant_i);
    load    = valid_i && ready_o && (rd_i != '0);
    full_d  = full_q;
    req_d   = req_q;
    if (load) begin
      full_d     = 1'b1;
      req_d.rd   = rd_i;
      req_d.data = data_i;
    end else if (grant_i) begin
      full_d = 1'b0;
    end
  end

  // Buffer state register, emptied by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

  assign full_o = full_q;
  assign rd_o   = req_q.rd;
  assign data_o = req_q.data;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between ALU and LSU writeback buffers.
// LSU wins by default; the ALU is forced through after STARVE_LIMIT losses.
// Optional load scoreboard and hazard flag: define WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import mips_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        issue_load_valid,
  input  logic [4:0]  issue_load_rd,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  output logic        hazard,
  output logic        wen,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                  alu_full, lsu_full;
  logic [REG_ADDR_W-1:0] alu_buf_rd, lsu_buf_rd;
  logic [DATA_W-1:0]     alu_buf_data, lsu_buf_data;
  wb_gnt_e               gnt;

  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [3:0]            starve_q, starve_d;

  wb_hold_buffer u_alu_buf (
    .clk     (clk),
    .reset   (reset),
    .valid_i (alu_valid),
    .rd_i    (alu_rd),
    .data_i  (alu_data),
    .grant_i (gnt == GNT_ALU),
    .ready_o (alu_ready),
    .full_o  (alu_full),
    .rd_o    (alu_buf_rd),
    .data_o  (alu_buf_data)
  );

  wb_hold_buffer u_lsu_buf (
    .clk     (clk),
    .reset   (reset),
    .valid_i (lsu_valid),
    .rd_i    (lsu_rd),
    .data_i  (lsu_data),
    .grant_i (gnt == GNT_LSU),
    .ready_o (lsu_ready),
    .full_o  (lsu_full),
    .rd_o    (lsu_buf_rd),
    .data_o  (lsu_buf_data)
  );

  // Pick the winner among full buffers and compute the ALU starvation count.
  always_comb begin
    gnt = GNT_NONE;
    if (alu_full && lsu_full) begin
      gnt = (starve_q == LIMIT) ? GNT_ALU : GNT_LSU;
    end else if (lsu_full) begin
      gnt = GNT_LSU;
    end else if (alu_full) begin
      gnt = GNT_ALU;
    end

    starve_d = starve_q;
    if (!alu_full || gnt == GNT_ALU) begin
      starve_d = '0;
    end else if (gnt == GNT_LSU && starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Next write-port values; address and data hold when nothing is granted.
  always_comb begin
    wen_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (gnt)
      GNT_ALU: begin
        wen_d     = 1'b1;
        wr_addr_d = alu_buf_rd;
        wr_data_d = alu_buf_data;
      end
      GNT_LSU: begin
        wen_d     = 1'b1;
        wr_addr_d = lsu_buf_rd;
        wr_data_d = lsu_buf_data;
      end
      default: ;
    endcase
  end

  // Registered write port and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      starve_q  <= '0;
    end else begin
      wen_q     <= wen_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      starve_q  <= starve_d;
    end
  end

  assign wen     = wen_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Clear on the LSU write of a pending register; a same-edge issue re-sets it.
  always_comb begin
    busy_d = busy_q;
    if (gnt == GNT_LSU) begin
      busy_d[lsu_buf_rd] = 1'b0;
    end
    if (issue_load_valid && issue_load_rd != '0) begin
      busy_d[issue_load_rd] = 1'b1;
    end
  end

  // Outstanding-load vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign hazard = busy_q[issue_rs] | busy_q[issue_rt];
`else
  logic unused_issue;
  assign unused_issue = ^{issue_load_valid, issue_load_rd, issue_rs, issue_rt};
  assign hazard       = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard testbench for regfile_wb_arbiter.
// Expected register-file writes are queued in the order the arbiter must
// issue them; a monitor pops one entry for every cycle wen is high.
module tb_regfile_wb_arbiter;
   import mips_wb_pkg::*;

   logic        clk;
   logic        reset;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid, lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_load_valid;
   logic [4:0]  issue_load_rd, issue_rs, issue_rt;
   logic        hazard;
   logic        wen;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int checkCount = 0;
   int errorCount = 0;
   wb_req_t expectQ[$];

   regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk              (clk),
      .reset            (reset),
      .alu_valid        (alu_valid),
      .alu_ready        (alu_ready),
      .alu_rd           (alu_rd),
      .alu_data         (alu_data),
      .lsu_valid        (lsu_valid),
      .lsu_ready        (lsu_ready),
      .lsu_rd           (lsu_rd),
      .lsu_data         (lsu_data),
      .issue_load_valid (issue_load_valid),
      .issue_load_rd    (issue_load_rd),
      .issue_rs         (issue_rs),
      .issue_rt         (issue_rt),
      .hazard           (hazard),
      .wen              (wen),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive both requester ports in one call
   task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aData,
                                input logic lV, input logic [4:0] lRd, input logic [31:0] lData);
      alu_valid = aV;
      alu_rd    = aRd;
      alu_data  = aData;
      lsu_valid = lV;
      lsu_rd    = lRd;
      lsu_data  = lData;
   endtask

   task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
      wb_req_t e;
      e.rd   = rd;
      e.data = data;
      expectQ.push_back(e);
   endtask

   // Advance past the next rising edge so inputs change away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write-port cycle must match the head of the expected queue
   always @(negedge clk) begin
      if (wen === 1'b1) begin
         if (expectQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpected write: got addr %0d data %h expected no write", wr_addr, wr_data);
         end else begin
            wb_req_t e;
            e = expectQ.pop_front();
            checkOutput("write addr", {27'd0, wr_addr}, {27'd0, e.rd});
            checkOutput("write data", wr_data, e.data);
         end
      end
   end

   initial begin
      int li;
      int ai;
      int budget;
      logic aAcc, lAcc;

      reset            = 1'b1;
      issue_load_valid = 1'b0;
      issue_load_rd    = '0;
      issue_rs         = '0;
      issue_rt         = '0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Reset state
      repeat (2) tick();
      @(negedge clk);
      checkOutput("ready alu in reset", {31'd0, alu_ready}, 32'd0);
      checkOutput("ready lsu in reset", {31'd0, lsu_ready}, 32'd0);
      checkOutput("wen in reset", {31'd0, wen}, 32'd0);
      checkOutput("wr_addr reset", {27'd0, wr_addr}, 32'd0);
      checkOutput("wr_data reset", wr_data, 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("ready alu after reset", {31'd0, alu_ready}, 32'd1);
      checkOutput("ready lsu after reset", {31'd0, lsu_ready}, 32'd1);
      checkOutput("hazard after reset", {31'd0, hazard}, 32'd0);

      // Single ALU write: port updated at the edge after acceptance
      tick();
      applyStimulus(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
      expectWrite(5'd5, 32'h0000_1234);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("alu_ready stays 1", {31'd0, alu_ready}, 32'd1);
      checkOutput("wen not yet", {31'd0, wen}, 32'd0);
      tick();
      @(negedge clk);
      checkOutput("single wen", {31'd0, wen}, 32'd1);
      checkOutput("single wr_addr", {27'd0, wr_addr}, 32'd5);
      checkOutput("single wr_data", wr_data, 32'h0000_1234);
      repeat (2) tick();

      // Simultaneous ALU and LSU: LSU first, ALU stalls one cycle
      applyStimulus(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd4, 32'hBBBB_0004);
      expectWrite(5'd4, 32'hBBBB_0004);
      expectWrite(5'd3, 32'hAAAA_0003);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("alu_ready while losing", {31'd0, alu_ready}, 32'd0);
      checkOutput("lsu_ready while winning", {31'd0, lsu_ready}, 32'd1);
      tick();
      @(negedge clk);
      checkOutput("alu_ready when granted", {31'd0, alu_ready}, 32'd1);
      checkOutput("lsu written first", {27'd0, wr_addr}, 32'd4);
      tick();
      @(negedge clk);
      checkOutput("alu written second", {27'd0, wr_addr}, 32'd3);
      repeat (2) tick();

      // Streaming both sides: 3 LSU writes then 1 ALU write, repeating
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 3; k++)
            expectWrite(5'(16 + 3*r + k), 32'hC000_0000 + 32'(3*r + k));
         expectWrite(5'(1 + r), 32'hA000_0000 + 32'(r));
      end
      li = 0;
      ai = 0;
      budget = 0;
      while ((li < 9 || ai < 3) && budget < 40) begin
         applyStimulus(ai < 3, 5'(1 + ai), 32'hA000_0000 + 32'(ai),
                       li < 9, 5'(16 + li), 32'hC000_0000 + 32'(li));
         @(negedge clk);
         aAcc = alu_valid && alu_ready;
         lAcc = lsu_valid && lsu_ready;
         tick();
         if (aAcc) ai++;
         if (lAcc) li++;
         budget++;
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checkOutput("stream lsu accepts", 32'(li), 32'd9);
      checkOutput("stream alu accepts", 32'(ai), 32'd3);
      repeat (5) tick();

      // Writes to r0 are accepted and dropped
      applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("r0 alu accepted", {31'd0, alu_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      checkOutput("r0 lsu accepted", {31'd0, lsu_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      repeat (4) tick();

`ifdef WB_SCOREBOARD_EN
      // Load to r8 issued, later instruction reads r8
      issue_load_valid = 1'b1;
      issue_load_rd    = 5'd8;
      tick();
      issue_load_valid = 1'b0;
      issue_rs         = 5'd8;
      @(negedge clk);
      checkOutput("hazard rs pending", {31'd0, hazard}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_0088);
      expectWrite(5'd8, 32'h0000_0088);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("hazard before grant", {31'd0, hazard}, 32'd1);
      tick();
      @(negedge clk);
      checkOutput("hazard after grant", {31'd0, hazard}, 32'd0);

      // New load to r8 on the same edge as the r8 load return: stays busy
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_0099);
      expectWrite(5'd8, 32'h0000_0099);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      issue_load_valid = 1'b1;
      issue_load_rd    = 5'd8;
      tick();
      issue_load_valid = 1'b0;
      issue_rs         = 5'd0;
      issue_rt         = 5'd8;
      @(negedge clk);
      checkOutput("set wins over clear", {31'd0, hazard}, 32'd1);
      tick();
`else
      // Without the scoreboard the issue inputs have no effect
      issue_load_valid = 1'b1;
      issue_load_rd    = 5'd8;
      tick();
      issue_load_valid = 1'b0;
      issue_rs         = 5'd8;
      issue_rt         = 5'd8;
      @(negedge clk);
      checkOutput("hazard tied low", {31'd0, hazard}, 32'd0);
      tick();
`endif

      // Reset with both buffers full discards the pending writes
      applyStimulus(1'b1, 5'd7, 32'h0000_0077, 1'b1, 5'd9, 32'h0000_0099);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("alu_ready during reset", {31'd0, alu_ready}, 32'd0);
      checkOutput("lsu_ready during reset", {31'd0, lsu_ready}, 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("alu_ready after mid reset", {31'd0, alu_ready}, 32'd1);
      checkOutput("lsu_ready after mid reset", {31'd0, lsu_ready}, 32'd1);
      checkOutput("wen after mid reset", {31'd0, wen}, 32'd0);
      checkOutput("busy cleared by reset", {31'd0, hazard}, 32'd0);
      repeat (5) tick();

      checkOutput("expected writes drained", 32'(expectQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
